// File: rtl/bcd_share_arbiter.sv
// Round-robin share of one binary->BCD converter; ack at T, out_valid at T+2, min 3 cycles/conversion.
// Backpressure: result held stable in RESP until out_ready; no new operand accepted meanwhile.

module binary_to_bcd (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [19:0] sr;

    // Double dabble; the hundreds nibble never exceeds 2 so it needs no adjust.
    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5) sr[11:8] = sr[11:8] + 4'd3;
            if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
            sr = sr << 1;
        end
        hundreds = sr[19:16];
        tens     = sr[15:12];
        ones     = sr[11:8];
    end
endmodule

module bcd_share_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [8*NUM_REQ-1:0]         value,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic [3:0]                   out_hundreds,
    output logic [3:0]                   out_tens,
    output logic [3:0]                   out_ones
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic [3:0]      hund_q, hund_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;

    logic [ID_W-1:0] hi_win, lo_win, winner;
    logic            found_hi;
    logic [7:0]      sel_val;
    logic [3:0]      bcd_h, bcd_t, bcd_o;

    binary_to_bcd u_bcd (
        .bin      (op_q),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_win   = '0;
        lo_win   = '0;
        found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) > last_grant_q)) begin
                hi_win   = ID_W'(i);
                found_hi = 1'b1;
            end
            if (req[i]) lo_win = ID_W'(i);
        end
        winner = found_hi ? hi_win : lo_win;
    end

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == winner) sel_val = value[8*k +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        out_id_d     = out_id_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        ack          = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    ack          = NUM_REQ'(1) << winner;
                    op_d         = sel_val;
                    id_d         = winner;
                    last_grant_d = winner;
                    state_d      = CONV;
                end
            end
            CONV: begin
                hund_d   = bcd_h;
                tens_d   = bcd_t;
                ones_d   = bcd_o;
                out_id_d = id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            out_id_q     <= '0;
            hund_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            out_id_q     <= out_id_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == RESP);
    assign out_id       = out_id_q;
    assign out_hundreds = hund_q;
    assign out_tens     = tens_q;
    assign out_ones     = ones_q;
endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Bench for bcd_share_arbiter: cycle model + result scoreboard checked on every falling edge.
module tb_bcd_share_arbiter;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] value;
    logic           out_ready;
    logic [N-1:0]   ack;
    logic           busy;
    logic           out_valid;
    logic [1:0]     out_id;
    logic [3:0]     out_hundreds, out_tens, out_ones;

    bcd_share_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .value        (value),
        .ack          (ack),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_hundreds (out_hundreds),
        .out_tens     (out_tens),
        .out_ones     (out_ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int h;
        int t;
        int o;
    } exp_t;

    exp_t sb[$];
    exp_t m_hold;
    exp_t cur;
    int   m_state;          // 0 idle, 1 conv, 2 resp
    int   m_last;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   results = 0;
    int   last_ack_cyc = 0;
    int   valid_cyc = 0;
    bit   prev_valid = 1'b0;
    bit   started = 1'b0;
    int   grant_log[$];
    int   grant_cyc[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model_bcd(input int id, input int v);
        exp_t r;
        r.id = id;
        r.h  = v / 100;
        r.t  = (v / 10) % 10;
        r.o  = v % 10;
        return r;
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        int exp_ack;
        cyc++;
        w = -1;
        exp_ack = 0;
        if (started) begin
            if (m_state == 0 && req != 0) begin
                w = rr(req, m_last);
                exp_ack = 1 << w;
            end
            chk("ack", int'(ack), exp_ack);
            chk("busy", int'(busy), int'(m_state != 0));
            chk("out_valid", int'(out_valid), int'(m_state == 2));
            cur = m_hold;
            if (m_state == 2) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() > 0) cur = sb[0];
            end
            chk("out_id", int'(out_id), cur.id);
            chk("hundreds", int'(out_hundreds), cur.h);
            chk("tens", int'(out_tens), cur.t);
            chk("ones", int'(out_ones), cur.o);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                    last_ack_cyc = cyc;
                end
            end
            if (out_valid && !prev_valid) valid_cyc = cyc;
            prev_valid = out_valid;
        end
        if (rst) begin
            started = 1'b1;
            m_state = 0;
            m_last  = N - 1;
            m_hold  = model_bcd(0, 0);
            sb.delete();
        end else if (started) begin
            case (m_state)
                0: if (w >= 0) begin
                    sb.push_back(model_bcd(w, int'(value[8*w +: 8])));
                    m_last  = w;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (out_ready) begin
                    if (sb.size() > 0) m_hold = sb.pop_front();
                    results++;
                    m_state = 0;
                end
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int id);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #1;
            if (ack[id]) got = 1'b1;
        end
        chk("ack_wait", int'(got), 1);
        step(1);
        req[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            step(1);
            if (!busy && !out_valid) idle = 1'b1;
        end
        chk("idle_wait", int'(idle), 1);
    endtask

    task automatic wait_grants(input int n);
        for (int k = 0; k < 40 && grant_log.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        chk("grant_wait", int'(grant_log.size() >= n), 1);
        step(1);
        req = '0;
    endtask

    task automatic do_conv(input int id, input int v, input bit idle_after);
        value[8*id +: 8] = 8'(v);
        req[id] = 1'b1;
        wait_ack(id);
        if (idle_after) wait_idle();
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        req = '0;
        value = '0;
        out_ready = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // basic conversion and latency
        do_conv(0, 173, 1'b1);
        chk("t1_latency", valid_cyc - last_ack_cyc, 2);
        chk("t1_id", int'(out_id), 0);
        chk("t1_hund", int'(out_hundreds), 1);
        chk("t1_tens", int'(out_tens), 7);
        chk("t1_ones", int'(out_ones), 3);

        // range limits
        do_conv(1, 0, 1'b1);
        chk("t2_zero", int'({out_hundreds, out_tens, out_ones}), 0);
        do_conv(1, 255, 1'b1);
        chk("t2_id", int'(out_id), 1);
        chk("t2_hund", int'(out_hundreds), 2);
        chk("t2_tens", int'(out_tens), 5);
        chk("t2_ones", int'(out_ones), 5);

        // fairness with all requesting
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        grant_log.delete();
        grant_cyc.delete();
        value = {8'd30, 8'd20, 8'd10};
        req = 3'b111;
        wait_grants(4);
        wait_idle();
        if (grant_log.size() >= 4) begin
            chk("t3_g0", grant_log[0], 0);
            chk("t3_g1", grant_log[1], 1);
            chk("t3_g2", grant_log[2], 2);
            chk("t3_g3", grant_log[3], 0);
            for (int i = 0; i < 3; i++) chk("t3_spacing", grant_cyc[i+1] - grant_cyc[i], 3);
        end

        // backpressure in RESP
        out_ready = 1'b0;
        do_conv(0, 42, 1'b0);
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", int'(out_valid), 1);
            chk("t4_digits", int'({out_hundreds, out_tens, out_ones}), 12'h042);
            value[7:0] = 8'd99;
            if (i == 1) req[1] = 1'b1;
            step(1);
        end
        out_ready = 1'b1;
        value[15:8] = 8'd64;
        wait_ack(1);
        wait_idle();
        chk("t4_id", int'(out_id), 1);
        chk("t4_digits_after", int'({out_hundreds, out_tens, out_ones}), 12'h064);

        // reset during CONV
        do_conv(2, 200, 1'b0);
        rst = 1'b1;
        step(1);
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_digits", int'({out_hundreds, out_tens, out_ones}), 0);
        rst = 1'b0;
        grant_log.delete();
        req = 3'b111;
        wait_grants(1);
        wait_idle();
        if (grant_log.size() > 0) chk("t5_first", grant_log[0], 0);

        // short request pulse while busy
        r0 = results;
        do_conv(2, 77, 1'b0);
        req[0] = 1'b1;
        step(1);
        req[0] = 1'b0;
        wait_idle();
        step(4);
        chk("t6_results", results - r0, 1);
        chk("t6_id", int'(out_id), 2);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
